// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file and a parallel local port.
// SCL/SDA are oversampled on clk: 2-flop synchronizer plus a 3-sample
// majority filter. SDA is only ever pulled low (open drain) and changes
// HOLD_CYC clk cycles after a filtered SCL fall. SCL is never driven.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  input  logic       loc_we_i,
  input  logic [3:0] loc_addr_i,
  input  logic [7:0] loc_wdata_i,
  output logic [7:0] loc_rdata_o,
  output logic       wr_valid_o,
  output logic [3:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ACK_ADDR = 4'd2,
    ST_PTR      = 4'd3,
    ST_ACK_PTR  = 4'd4,
    ST_WDATA    = 4'd5,
    ST_ACK_W    = 4'd6,
    ST_RDATA    = 4'd7,
    ST_RACK     = 4'd8,
    ST_IGNORE   = 4'd9
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           state_r, state_nx;
  logic [1:0]       scl_sync_r, sda_sync_r, scl_hist_r, sda_hist_r;
  logic             scl_filt_r, sda_filt_r, scl_prev_r, sda_prev_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_cnt_r;
  logic [3:0]       ptr_r;
  logic             rw_r;
  logic [7:0]       regs_r [16];
  logic             wr_valid_r, busy_r, sda_oen_r;
  logic [3:0]       wr_addr_r;
  logic [7:0]       wr_data_r;
  logic [CNT_W-1:0] hold_cnt_r;

  logic       scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s;
  logic       byte_state_s, shift_in_state_s, drive_low_s;
  logic       commit_s, ptr_load_s, ptr_adv_s, rd_load_s;
  logic [3:0] ptr_inc_s, rd_idx_s;
  logic [7:0] byte_s;

  // Synchronize and majority-filter the bus lines; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_i};
      sda_sync_r <= {sda_sync_r[0], sda_i};
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      scl_filt_r <= maj3(scl_sync_r[1], scl_hist_r[0], scl_hist_r[1]);
      sda_filt_r <= maj3(sda_sync_r[1], sda_hist_r[0], sda_hist_r[1]);
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  assign scl_rise_s       = scl_filt_r & ~scl_prev_r;
  assign scl_fall_s       = ~scl_filt_r & scl_prev_r;
  assign start_s          = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
  assign stop_s           = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
  assign byte_s           = {shift_r[6:0], sda_filt_r};
  assign last_bit_s       = (bit_cnt_r == 3'd7);
  assign ptr_inc_s        = ptr_r + 4'd1;
  assign shift_in_state_s = (state_r == ST_ADDR) | (state_r == ST_PTR) | (state_r == ST_WDATA);
  assign byte_state_s     = shift_in_state_s | (state_r == ST_RDATA);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and datapath strobes; START/STOP override any bit activity.
  always_comb begin
    state_nx   = state_r;
    commit_s   = 1'b0;
    ptr_load_s = 1'b0;
    ptr_adv_s  = 1'b0;
    rd_load_s  = 1'b0;
    rd_idx_s   = ptr_r;
    if (start_s) begin
      state_nx = ST_ADDR;
    end else if (stop_s) begin
      state_nx = ST_IDLE;
    end else if (scl_rise_s) begin
      case (state_r)
        ST_ADDR: begin
          if (last_bit_s) begin
            if (byte_s[7:1] == DEV_ADDR) state_nx = ST_ACK_ADDR;
            else                         state_nx = ST_IGNORE;
          end else begin
            state_nx = ST_ADDR;
          end
        end
        ST_ACK_ADDR: begin
          if (rw_r) begin
            rd_load_s = 1'b1;
            state_nx  = ST_RDATA;
          end else begin
            state_nx  = ST_PTR;
          end
        end
        ST_PTR: begin
          if (last_bit_s) begin
            ptr_load_s = 1'b1;
            state_nx   = ST_ACK_PTR;
          end else begin
            state_nx   = ST_PTR;
          end
        end
        ST_ACK_PTR: state_nx = ST_WDATA;
        ST_WDATA: begin
          if (last_bit_s) begin
            commit_s = 1'b1;
            state_nx = ST_ACK_W;
          end else begin
            state_nx = ST_WDATA;
          end
        end
        ST_ACK_W: state_nx = ST_WDATA;
        ST_RDATA: begin
          if (last_bit_s) state_nx = ST_RACK;
          else            state_nx = ST_RDATA;
        end
        ST_RACK: begin
          if (!sda_filt_r) begin
            ptr_adv_s = 1'b1;
            rd_load_s = 1'b1;
            rd_idx_s  = ptr_inc_s;
            state_nx  = ST_RDATA;
          end else begin
            state_nx  = ST_IGNORE;
          end
        end
        default: state_nx = state_r;
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  // Shifter, bit counter, pointer, commit outputs and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      ptr_r      <= 4'd0;
      rw_r       <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 4'd0;
      wr_data_r  <= 8'h00;
      busy_r     <= 1'b0;
    end else begin
      wr_valid_r <= commit_s;
      if (commit_s) begin
        wr_addr_r <= ptr_r;
        wr_data_r <= byte_s;
      end
      if (start_s || stop_s) begin
        bit_cnt_r <= 3'd0;
      end else if (scl_rise_s && byte_state_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (rd_load_s) begin
        shift_r <= regs_r[rd_idx_s];
      end else if (scl_rise_s && (state_r == ST_RDATA)) begin
        shift_r <= {shift_r[6:0], 1'b0};
      end else if (scl_rise_s && shift_in_state_s) begin
        shift_r <= byte_s;
      end
      if (ptr_load_s) begin
        ptr_r <= byte_s[3:0];
      end else if (commit_s || ptr_adv_s) begin
        ptr_r <= ptr_inc_s;
      end
      if ((state_r == ST_ADDR) && scl_rise_s && last_bit_s) begin
        rw_r <= byte_s[0];
      end
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (stop_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Register file: the I2C commit is written last so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
    end else begin
      if (loc_we_i) regs_r[loc_addr_i] <= loc_wdata_i;
      if (commit_s) regs_r[ptr_r] <= byte_s;
    end
  end

  // What SDA should be once the hold delay after an SCL fall expires.
  always_comb begin
    drive_low_s = 1'b0;
    case (state_r)
      ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_W: drive_low_s = 1'b1;
      ST_RDATA:                          drive_low_s = ~shift_r[7];
      default:                           drive_low_s = 1'b0;
    endcase
  end

  // SDA enable changes only HOLD_CYC cycles after a filtered SCL fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oen_r  <= 1'b1;
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (start_s || stop_s) begin
      sda_oen_r  <= 1'b1;
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (scl_fall_s) begin
      hold_cnt_r <= CNT_W'(HOLD_CYC);
    end else if (hold_cnt_r != {CNT_W{1'b0}}) begin
      hold_cnt_r <= hold_cnt_r - CNT_W'(1);
      if (hold_cnt_r == CNT_W'(1)) sda_oen_r <= ~drive_low_s;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_oen_o   = sda_oen_r;
  assign loc_rdata_o = regs_r[loc_addr_i];
  assign wr_valid_o  = wr_valid_r;
  assign wr_addr_o   = wr_addr_r;
  assign wr_data_o   = wr_data_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on an
// open-drain bus model (SCL period 24 clk) plus the local register port.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_g = 1'b0;
  logic       scl_i, sda_i, sda_o, sda_oen_o, sda_bus;
  logic       loc_we_i = 1'b0;
  logic [3:0] loc_addr_i = 4'd0;
  logic [7:0] loc_wdata_i = 8'h00;
  logic [7:0] loc_rdata_o;
  logic       wr_valid_o, busy_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  int          total = 0;
  int          bad = 0;
  int          oen_low_cnt = 0;
  logic [11:0] wr_log [$];

  assign sda_bus = sda_m & (sda_oen_o | sda_o);
  assign sda_i   = sda_bus;
  assign scl_i   = scl_m ^ scl_g;

  i2c_target_regs #(.DEV_ADDR(7'h50), .HOLD_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .sda_o(sda_o), .sda_oen_o(sda_oen_o),
    .loc_we_i(loc_we_i), .loc_addr_i(loc_addr_i), .loc_wdata_i(loc_wdata_i),
    .loc_rdata_o(loc_rdata_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Log commit pulses and count cycles where the target pulls SDA low.
  always @(negedge clk) begin
    if (wr_valid_o) wr_log.push_back({wr_addr_o, wr_data_o});
    if (!sda_oen_o) oen_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting and ending just at an SCL fall; s = bus sampled mid-high.
  task automatic xfer_bit(input logic b, input logic glitch, output logic s);
    wait_clk(6);
    sda_m = b;
    if (glitch) begin
      wait_clk(3);
      scl_g = 1'b1;
      wait_clk(1);
      scl_g = 1'b0;
      wait_clk(2);
    end else begin
      wait_clk(6);
    end
    scl_m = 1'b1;
    wait_clk(6);
    s = sda_bus;
    wait_clk(6);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(6);
    sda_m = 1'b1;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(6);
    sda_m = 1'b0;
    wait_clk(6);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(6);
    sda_m = 1'b0;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(6);
    sda_m = 1'b1;
    wait_clk(12);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) xfer_bit(d[7-i], (i == glitch_bit), s);
    xfer_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    xfer_bit(nack, 1'b0, s);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    loc_we_i = 1'b1;
    loc_addr_i = a;
    loc_wdata_i = d;
    wait_clk(1);
    loc_we_i = 1'b0;
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
    loc_addr_i = a;
    #1;
    d = loc_rdata_o;
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    logic [7:0] addr_rd;
    int         snap, nz;

    // Reset state
    wait_clk(3);
    check("rst_oen", sda_oen_o, 1);
    check("rst_sda_o", sda_o, 0);
    check("rst_wr_valid", wr_valid_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_busy", busy_o, 0);
    loc_read(4'd5, rd);
    check("rst_reg5", rd, 8'h00);
    rst_n = 1'b1;
    wait_clk(10);

    // Write 0x50+W, pointer 3, data A5 5A
    i2c_start();
    write_byte(8'hA0, -1, ack); check("w1_ack_addr", ack, 0);
    check("w1_busy", busy_o, 1);
    write_byte(8'h03, -1, ack); check("w1_ack_ptr", ack, 0);
    write_byte(8'hA5, -1, ack); check("w1_ack_d0", ack, 0);
    write_byte(8'h5A, -1, ack); check("w1_ack_d1", ack, 0);
    i2c_stop();
    check("w1_busy_after", busy_o, 0);
    loc_read(4'd3, rd); check("w1_reg3", rd, 8'hA5);
    loc_read(4'd4, rd); check("w1_reg4", rd, 8'h5A);
    check("w1_wr_count", wr_log.size(), 2);
    check("w1_wr0", wr_log[0], 12'h3A5);
    check("w1_wr1", wr_log[1], 12'h45A);

    // Read across the 15 -> 0 wrap with repeated START
    loc_write(4'd15, 8'h11);
    loc_write(4'd0, 8'h22);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("r2_ack_addr", ack, 0);
    write_byte(8'h0F, -1, ack); check("r2_ack_ptr", ack, 0);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("r2_ack_raddr", ack, 0);
    read_byte(1'b0, rd); check("r2_byte0", rd, 8'h11);
    read_byte(1'b1, rd); check("r2_byte1", rd, 8'h22);
    i2c_stop();

    // Wrong address: never driven, nothing committed
    snap = oen_low_cnt;
    i2c_start();
    write_byte(8'hA2, -1, ack); check("n3_ack_addr", ack, 1);
    write_byte(8'h77, -1, ack); check("n3_ack_data", ack, 1);
    i2c_stop();
    check("n3_oen_low_cycles", oen_low_cnt - snap, 0);
    check("n3_wr_count", wr_log.size(), 2);

    // STOP after 4 data bits aborts the byte
    loc_write(4'd8, 8'h3C);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("s4_ack_addr", ack, 0);
    write_byte(8'h08, -1, ack); check("s4_ack_ptr", ack, 0);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, 1'b0, s);
    i2c_stop();
    check("s4_wr_count", wr_log.size(), 2);
    loc_read(4'd8, rd); check("s4_reg8_local", rd, 8'h3C);
    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h08, -1, ack);
    i2c_start();
    write_byte(8'hA1, -1, ack);
    read_byte(1'b1, rd); check("s4_reg8_i2c", rd, 8'h3C);
    i2c_stop();

    // Reset while the target holds SDA low in the read address ACK
    addr_rd = 8'hA1;
    i2c_start();
    for (int i = 0; i < 8; i++) xfer_bit(addr_rd[7-i], 1'b0, s);
    wait_clk(6);
    sda_m = 1'b1;
    wait_clk(6);
    scl_m = 1'b1;
    wait_clk(6);
    check("r5_oen_before", sda_oen_o, 0);
    rst_n = 1'b0;
    #1;
    check("r5_oen_async", sda_oen_o, 1);
    check("r5_busy", busy_o, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      loc_read(i[3:0], rd);
      if (rd !== 8'h00) nz++;
    end
    check("r5_regs_zero", nz, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    scl_m = 1'b0;
    i2c_stop();

    // 1-cycle SCL glitch during a data bit's low phase
    i2c_start();
    write_byte(8'hA0, -1, ack); check("g6_ack_addr", ack, 0);
    write_byte(8'h07, -1, ack); check("g6_ack_ptr", ack, 0);
    write_byte(8'hC3, 3, ack);  check("g6_ack_data", ack, 0);
    i2c_stop();
    loc_read(4'd7, rd); check("g6_reg7", rd, 8'hC3);
    check("g6_wr_count", wr_log.size(), 3);
    check("g6_wr2", wr_log[2], 12'h7C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
